// File: rtl/nios_sampler_capture_writer.sv
// Arm/trigger capture of a byte stream into a 32-bit RAM used as a circular byte buffer.
// Optional input decimation is enabled by defining CAPTURE_DECIM_EN.
module nios_sampler_capture_writer #(
  parameter int ADDR_W    = 10,
  parameter int POST_TRIG = 2048
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              sample_valid,
  input  logic [7:0]        sample_data,
  input  logic              trigger,
`ifdef CAPTURE_DECIM_EN
  input  logic [3:0]        decim,
`endif
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W+1:0] trig_addr
);

  localparam int PW = ADDR_W + 2;
  localparam logic [PW-1:0] POST_N = PW'(POST_TRIG);

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] ptr;
  logic [PW-1:0] post_cnt;
  logic          rearm;
  logic          capturing;
  logic          keep;
  logic          take;
  logic          fire;

  assign rearm = arm && (state == IDLE || state == DONE);
  // Once the post count is full no further sample may be written.
  assign capturing = (state == ARMED) ||
                     (state == POST && post_cnt != POST_N);
  assign take = sample_valid && capturing && keep;
  assign fire = take && trigger && (state == ARMED);

  assign busy = (state == ARMED) || (state == POST);
  assign done = (state == DONE);

`ifdef CAPTURE_DECIM_EN
  logic [3:0] dcnt;
  logic [3:0] decim_q;

  assign keep = (dcnt == 4'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dcnt    <= '0;
      decim_q <= '0;
    end else if (rearm) begin
      dcnt    <= '0;
      decim_q <= decim;
    end else if (sample_valid && capturing) begin
      dcnt <= (dcnt == decim_q) ? 4'd0 : dcnt + 4'd1;
    end
  end
`else
  assign keep = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (arm) state_nx = ARMED;
      ARMED: if (fire) state_nx = POST;
      POST:  if (post_cnt == POST_N) state_nx = DONE;
      DONE:  if (arm) state_nx = ARMED;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      post_cnt   <= '0;
      trig_addr  <= '0;
      address    <= '0;
      byteenable <= '0;
      chipselect <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
    end else begin
      state <= state_nx;
      if (rearm) begin
        ptr <= '0;
      end else if (take) begin
        ptr <= ptr + 1'b1;
      end
      if (fire) begin
        trig_addr <= ptr;
        post_cnt  <= '0;
      end else if (take && state == POST) begin
        post_cnt <= post_cnt + 1'b1;
      end
      chipselect <= take;
      write      <= take;
      if (take) begin
        address    <= ptr[PW-1:2];
        byteenable <= 4'd1 << ptr[1:0];
        writedata  <= {4{sample_data}};
      end
    end
  end

endmodule

// File: tb/tb_nios_sampler_capture_writer.sv
// Scoreboard bench for nios_sampler_capture_writer (16-byte buffer, 4 post-trigger samples).
// Driver pushes expected RAM writes; a negedge monitor pops and compares them.
module tb_nios_sampler_capture_writer;

  localparam int AW = 2;
  localparam int PT = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm = 1'b0;
  logic          sample_valid = 1'b0;
  logic [7:0]    sample_data = '0;
  logic          trigger = 1'b0;
`ifdef CAPTURE_DECIM_EN
  logic [3:0]    decim = '0;
`endif
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          write;
  logic [31:0]   writedata;
  logic          busy;
  logic          done;
  logic [AW+1:0] trig_addr;

  nios_sampler_capture_writer #(.ADDR_W(AW), .POST_TRIG(PT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .arm(arm),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .trigger(trigger),
`ifdef CAPTURE_DECIM_EN
    .decim(decim),
`endif
    .address(address),
    .byteenable(byteenable),
    .chipselect(chipselect),
    .write(write),
    .writedata(writedata),
    .busy(busy),
    .done(done),
    .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [31:0]   d;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  failures = 0;
  int  mp = 0;
  bit  mon = 1'b0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_t w;
    logic [AW+1:0] p;
    p = mp[AW+1:0];
    w.a = p[AW+1:2];
    w.be = 4'd1 << p[1:0];
    w.d = {4{d}};
    q.push_back(w);
    mp = (mp + 1) % (4 << AW);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic t, input bit exp);
    sample_valid = 1'b1;
    sample_data = d;
    trigger = t;
    if (exp) push(d);
    tick();
    sample_valid = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    mp = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    mp = 0;
  endtask

  always @(negedge clk) begin
    if (mon && write) begin
      wr_t w;
      chk("chipselect", {31'd0, chipselect}, 32'd1);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual_addr=%0d expected=none",
                 address);
      end else begin
        w = q.pop_front();
        chk("address", {30'd0, address}, {30'd0, w.a});
        chk("byteenable", {28'd0, byteenable}, {28'd0, w.be});
        chk("writedata", writedata, w.d);
      end
    end
  end

  initial begin
    do_reset();
    mon = 1'b1;
    @(negedge clk);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_trig", {28'd0, trig_addr}, 32'd0);
    chk("rst_addr", {30'd0, address}, 32'd0);

    for (int i = 0; i < 16; i++) send(8'h11 + 8'(i), i == 3, 1'b0);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);

    pulse_arm();
    for (int i = 0; i < 10; i++) send(8'hA0 + 8'(i), i == 5, 1'b1);
    @(negedge clk);
    chk("post_full_done", {31'd0, done}, 32'd0);
    chk("post_full_busy", {31'd0, busy}, 32'd1);
    send(8'hAA, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    chk("t2_trig", {28'd0, trig_addr}, 32'd5);
    send(8'hAB, 1'b1, 1'b0);

    pulse_arm();
    @(negedge clk);
    chk("rearm_done", {31'd0, done}, 32'd0);
    chk("rearm_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      arm = (i == 10);
      send(8'h30 + 8'(i), 1'b0, 1'b1);
      arm = 1'b0;
    end
    send(8'h44, 1'b1, 1'b1);
    for (int i = 0; i < PT; i++) send(8'h45 + 8'(i), 1'b0, 1'b1);
    send(8'h49, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_trig", {28'd0, trig_addr}, 32'd4);

    pulse_arm();
    send(8'h60, 1'b0, 1'b1);
    send(8'h61, 1'b1, 1'b1);
    reset_n = 1'b0;
    send(8'h62, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_rst_write", {31'd0, write}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_trig", {28'd0, trig_addr}, 32'd0);
    reset_n = 1'b1;
    mp = 0;
    pulse_arm();
    send(8'h70, 1'b0, 1'b1);
    send(8'h71, 1'b0, 1'b1);
    @(negedge clk);
    chk("restart_busy", {31'd0, busy}, 32'd1);

`ifdef CAPTURE_DECIM_EN
    do_reset();
    decim = 4'd2;
    pulse_arm();
    decim = 4'd0;
    for (int i = 0; i < 9; i++) send(8'(i), 1'b0, (i % 3) == 0);
`endif

    repeat (3) tick();
    chk("queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
